// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_ctrl.sv
// Signature collection controller for the scan write-thru observation flops:
// arms, compresses obs_in into a MISR for a programmed count, then unloads it MSB first.
module arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_ctrl #(
    parameter int                      OBS_FLOP_NUM = 8,
    parameter logic [OBS_FLOP_NUM-1:0] MISR_POLY    = 8'h1D,
    parameter int                      CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset_b,
    input  logic [OBS_FLOP_NUM-1:0] obs_in,
    input  logic                    start,
    input  logic [CNT_W-1:0]        capture_cycles,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [OBS_FLOP_NUM-1:0] signature,
    output logic                    sig_sout,
    output logic                    sig_sout_valid,
    input  logic                    sig_sout_ready,
    input  logic                    unload_req
);

    localparam int                IDX_W   = $clog2(OBS_FLOP_NUM);
    localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(OBS_FLOP_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE,
        UNLOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [OBS_FLOP_NUM-1:0] misr_q, misr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;

    function automatic logic [OBS_FLOP_NUM-1:0] misr_step(
        input logic [OBS_FLOP_NUM-1:0] cur,
        input logic [OBS_FLOP_NUM-1:0] obs
    );
        logic [OBS_FLOP_NUM-1:0] fb;
        fb = cur[OBS_FLOP_NUM-1] ? MISR_POLY : '0;
        return {cur[OBS_FLOP_NUM-2:0], 1'b0} ^ fb ^ obs;
    endfunction

    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            misr_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        misr_d = '0;
                        cnt_d  = capture_cycles;
                        if (capture_cycles == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ARM;
                        end
                    end
                end
                // obs_in is not trusted until the first falling-edge capture settles
                ARM: state_d = CAPTURE;
                CAPTURE: begin
                    misr_d = misr_step(misr_q, obs_in);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    if (unload_req) begin
                        state_d = UNLOAD;
                        idx_d   = IDX_MSB;
                    end
                end
                UNLOAD: begin
                    if (sig_sout_ready) begin
                        if (idx_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            misr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy           = (state_q == ARM) || (state_q == CAPTURE) || (state_q == UNLOAD);
    assign done           = done_q;
    assign signature      = misr_q;
    assign sig_sout_valid = (state_q == UNLOAD);
    assign sig_sout       = sig_sout_valid & misr_q[idx_q];

endmodule

// File: tb/tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_ctrl.sv
// Bench for the observation MISR controller: directed scenarios plus randomized
// captures/unloads checked against a GF(2) polynomial signature model.
module tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_ctrl;

    logic       clock = 1'b0;
    logic       reset_b;
    logic [3:0] obs_in;
    logic       start;
    logic [7:0] capture_cycles;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] signature;
    logic       sig_sout;
    logic       sig_sout_valid;
    logic       sig_sout_ready;
    logic       unload_req;

    int checks = 0;
    int errors = 0;

    logic [3:0] obs_hist[$];
    logic [3:0] dir_obs[$];
    logic [3:0] sig;

    arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_ctrl #(
        .OBS_FLOP_NUM(4),
        .MISR_POLY   (4'b0011),
        .CNT_W       (8)
    ) dut (
        .clock         (clock),
        .reset_b       (reset_b),
        .obs_in        (obs_in),
        .start         (start),
        .capture_cycles(capture_cycles),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .signature     (signature),
        .sig_sout      (sig_sout),
        .sig_sout_valid(sig_sout_valid),
        .sig_sout_ready(sig_sout_ready),
        .unload_req    (unload_req)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Signature as polynomial arithmetic over GF(2): s = s*x mod (x^4+x+1) + obs
    function automatic logic [3:0] model_sig();
        int m = 0;
        foreach (obs_hist[i]) begin
            m = m * 2;
            if (m >= 16) m = m ^ 'h13;
            m = m ^ int'(obs_hist[i]);
        end
        return 4'(m);
    endfunction

    task automatic run_cap(input int cap, input int restart_at, input int abort_at,
                           output logic [3:0] exp_sig);
        obs_hist.delete();
        start          = 1'b1;
        capture_cycles = 8'(cap);
        obs_in         = 4'($urandom);
        tick();
        start          = 1'b0;
        capture_cycles = 8'($urandom);
        if (cap == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_sig", signature, 0);
            exp_sig = 4'h0;
            tick();
            chk("zero_done_once", done, 0);
            chk("zero_busy_after", busy, 0);
            return;
        end
        chk("arm_busy", busy, 1);
        chk("arm_done", done, 0);
        chk("arm_sig_clr", signature, 0);
        obs_in = 4'($urandom);
        tick();
        for (int i = 0; i < cap; i++) begin
            obs_in = (i < dir_obs.size()) ? dir_obs[i] : 4'($urandom);
            start  = (i == restart_at);
            abort  = (i == abort_at);
            chk("cap_sig", signature, model_sig());
            chk("cap_no_done", done, 0);
            chk("cap_busy", busy, 1);
            obs_hist.push_back(obs_in);
            tick();
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_sig", signature, 0);
                chk("abort_done", done, 0);
                tick();
                chk("abort_no_done", done, 0);
                chk("abort_idle", busy, 0);
                exp_sig = 4'h0;
                return;
            end
        end
        exp_sig = model_sig();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("signature", signature, exp_sig);
        tick();
        chk("done_once", done, 0);
        chk("sig_hold", signature, exp_sig);
    endtask

    task automatic run_unload(input logic [3:0] exp_sig, input int stall_bit,
                              input int stall_len, input bit rnd);
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
        for (int b = 3; b >= 0; b--) begin
            int st;
            st = (b == stall_bit) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < st; s++) begin
                sig_sout_ready = 1'b0;
                chk("stall_valid", sig_sout_valid, 1);
                chk("stall_sout", sig_sout, exp_sig[b]);
                tick();
            end
            sig_sout_ready = 1'b1;
            chk("sout_valid", sig_sout_valid, 1);
            chk("sout_bit", sig_sout, exp_sig[b]);
            chk("unload_busy", busy, 1);
            chk("unload_sig", signature, exp_sig);
            tick();
        end
        chk("unload_end_valid", sig_sout_valid, 0);
        chk("unload_end_busy", busy, 0);
        chk("unload_end_sig", signature, exp_sig);
    endtask

    initial begin
        reset_b        = 1'b0;
        obs_in         = 4'h0;
        start          = 1'b0;
        capture_cycles = 8'h0;
        abort          = 1'b0;
        sig_sout_ready = 1'b1;
        unload_req     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", signature, 0);
        chk("rst_valid", sig_sout_valid, 0);
        chk("rst_sout", sig_sout, 0);
        @(negedge clock);
        reset_b = 1'b1;
        tick();

        // Directed: obs 1000 then 0001 gives signature 2, unload 0,0,1,0
        dir_obs = '{4'b1000, 4'b0001};
        run_cap(2, -1, -1, sig);
        chk("tp1_sig", signature, 4'h2);
        run_unload(4'h2, -1, 0, 1'b0);
        run_cap(2, -1, -1, sig);
        run_unload(4'h2, 2, 3, 1'b0);
        dir_obs.delete();

        // unload_req in IDLE is ignored
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
        chk("unl_idle_valid", sig_sout_valid, 0);
        chk("unl_idle_busy", busy, 0);

        run_cap(0, -1, -1, sig);
        run_unload(sig, -1, 0, 1'b0);

        // Start during CAPTURE is ignored; aborts mid-capture and on the final update
        run_cap(6, 1, -1, sig);
        run_unload(sig, -1, 0, 1'b1);
        run_cap(10, 2, 4, sig);
        run_cap(3, -1, 2, sig);

        // Abort beats a zero-length start that would otherwise pulse done
        dir_obs = '{4'hF, 4'h9, 4'h6};
        run_cap(3, -1, -1, sig);
        dir_obs.delete();
        run_unload(sig, -1, 0, 1'b0);
        start          = 1'b1;
        abort          = 1'b1;
        capture_cycles = 8'h0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_pri_done", done, 0);
        chk("abort_pri_busy", busy, 0);
        chk("abort_pri_sig", signature, 0);

        run_cap(255, -1, -1, sig);
        run_unload(sig, -1, 0, 1'b1);

        // Asynchronous reset mid-unload
        run_cap(3, -1, -1, sig);
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", sig_sout_valid, 1);
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_valid", sig_sout_valid, 0);
        chk("arst_sout", sig_sout, 0);
        chk("arst_sig", signature, 0);
        @(negedge clock);
        reset_b = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        run_cap(5, -1, -1, sig);
        run_unload(sig, -1, 0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            run_cap(int'($urandom_range(0, 12)), -1, -1, sig);
            run_unload(sig, -1, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
